// File: rtl/ex_muldiv_unit_pkg.sv
// ============================================================================
// Module   : ex_muldiv_unit_pkg
// Brief    : Shared op/state encodings and helpers for the EX mul/div unit.
// Revision : 1.0
// ============================================================================
`default_nettype none

package ex_muldiv_unit_pkg;

  localparam int DEFAULT_WIDTH = 32;

  localparam logic [2:0] MULDIV_OP_MULT  = 3'b000;
  localparam logic [2:0] MULDIV_OP_MULTU = 3'b001;
  localparam logic [2:0] MULDIV_OP_DIV   = 3'b010;
  localparam logic [2:0] MULDIV_OP_DIVU  = 3'b011;
  localparam logic [2:0] MULDIV_OP_MTHI  = 3'b100;
  localparam logic [2:0] MULDIV_OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } state_t;

  function automatic logic op_is_signed(input logic [2:0] op);
    return (op == MULDIV_OP_MULT) || (op == MULDIV_OP_DIV);
  endfunction

  function automatic logic op_is_mul(input logic [2:0] op);
    return (op == MULDIV_OP_MULT) || (op == MULDIV_OP_MULTU);
  endfunction

  function automatic logic op_is_div(input logic [2:0] op);
    return (op == MULDIV_OP_DIV) || (op == MULDIV_OP_DIVU);
  endfunction

endpackage

`default_nettype wire

// File: rtl/ex_muldiv_unit_signfix.sv
// ============================================================================
// Module   : muldiv_signfix
// Brief    : Turns magnitude product / quotient+remainder into signed HI/LO.
// Revision : 1.0
// ============================================================================
`default_nettype none

module muldiv_signfix
  import ex_muldiv_unit_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               is_div,
  input  logic               sign_a,
  input  logic               sign_b,
  input  logic [2*WIDTH-1:0] mag,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo
);

  logic               w_neg;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;

  assign w_neg  = sign_a ^ sign_b;
  assign w_prod = w_neg ? -mag : mag;
  // Divide packs {remainder, quotient}; remainder follows the dividend's sign.
  assign w_quo  = w_neg  ? -mag[WIDTH-1:0]       : mag[WIDTH-1:0];
  assign w_rem  = sign_a ? -mag[2*WIDTH-1:WIDTH] : mag[2*WIDTH-1:WIDTH];

  assign hi = is_div ? w_rem : w_prod[2*WIDTH-1:WIDTH];
  assign lo = is_div ? w_quo : w_prod[WIDTH-1:0];

endmodule

`default_nettype wire

// File: rtl/ex_muldiv_unit.sv
// ============================================================================
// Module   : ex_muldiv_unit
// Brief    : Multi-cycle EX-stage multiply/divide unit owning HI/LO; stalls DE
//            readers while busy. MULDIV_FAST_MUL_EN selects a 1-cycle multiply.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ex_muldiv_unit
  import ex_muldiv_unit_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             EX_C_Start,
  input  logic [2:0]       EX_C_Op,
  input  logic             EX_C_Flush,
  input  logic [WIDTH-1:0] EX_OperandA,
  input  logic [WIDTH-1:0] EX_OperandB,
  input  logic             DE_C_ReadHiLo,
  output logic             HZ_C_StallReq,
  output logic             EX_C_Busy,
  output logic             EX_C_Done,
  output logic             EX_C_DivZero,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t             r_state, w_next_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_opb;
  logic [WIDTH-1:0]   r_raw_a;
  logic               r_sign_a, r_sign_b, r_is_div, r_div_zero_op;
  logic [WIDTH-1:0]   r_hi, r_lo;
  logic               r_done, r_divzero;

  logic               w_accept, w_neg_a, w_neg_b, w_b_zero;
  logic [WIDTH-1:0]   w_abs_a, w_abs_b;
  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_mul_step;
  logic [WIDTH:0]     w_rem_shift;
  logic [WIDTH+1:0]   w_div_diff;
  logic [2*WIDTH-1:0] w_div_step;
  logic [WIDTH-1:0]   w_fix_hi, w_fix_lo;

  assign w_accept = (r_state == ST_IDLE) & EX_C_Start & ~EX_C_Flush;
  assign w_neg_a  = op_is_signed(EX_C_Op) & EX_OperandA[WIDTH-1];
  assign w_neg_b  = op_is_signed(EX_C_Op) & EX_OperandB[WIDTH-1];
  // Magnitudes stay unsigned WIDTH-bit, so the most-negative value is exact.
  assign w_abs_a  = w_neg_a ? -EX_OperandA : EX_OperandA;
  assign w_abs_b  = w_neg_b ? -EX_OperandB : EX_OperandB;
  assign w_b_zero = (EX_OperandB == '0);

  // Shift-add step: accumulator is {partial product, remaining multiplier}.
  assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_opb};
  assign w_mul_step = r_acc[0] ? {w_mul_sum, r_acc[WIDTH-1:1]}
                               : {1'b0, r_acc[2*WIDTH-1:1]};

  // Restoring step: accumulator is {partial remainder, dividend/quotient}.
  assign w_rem_shift = r_acc[2*WIDTH-1:WIDTH-1];
  assign w_div_diff  = {1'b0, w_rem_shift} - {2'b00, r_opb};
  assign w_div_step  = w_div_diff[WIDTH+1]
                     ? {w_rem_shift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                     : {w_div_diff[WIDTH-1:0],  r_acc[WIDTH-2:0], 1'b1};

`ifdef MULDIV_FAST_MUL_EN
  logic [2*WIDTH-1:0] w_fast_prod;
  assign w_fast_prod = {{WIDTH{1'b0}}, w_abs_a} * {{WIDTH{1'b0}}, w_abs_b};
`endif

  muldiv_signfix #(.WIDTH(WIDTH)) u_signfix (
    .is_div (r_is_div),
    .sign_a (r_sign_a),
    .sign_b (r_sign_b),
    .mag    (r_acc),
    .hi     (w_fix_hi),
    .lo     (w_fix_lo)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept && op_is_div(EX_C_Op)) begin
          w_next_state = w_b_zero ? ST_FIX : ST_DIV;
        end else if (w_accept && op_is_mul(EX_C_Op)) begin
`ifdef MULDIV_FAST_MUL_EN
          w_next_state = ST_FIX;
`else
          w_next_state = ST_MUL;
`endif
        end
      end
      ST_MUL, ST_DIV: if (r_cnt == CNT_ONE) w_next_state = ST_FIX;
      ST_FIX:  w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt         <= '0;
      r_acc         <= '0;
      r_opb         <= '0;
      r_raw_a       <= '0;
      r_sign_a      <= 1'b0;
      r_sign_b      <= 1'b0;
      r_is_div      <= 1'b0;
      r_div_zero_op <= 1'b0;
      r_hi          <= '0;
      r_lo          <= '0;
      r_done        <= 1'b0;
      r_divzero     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_accept && EX_C_Op == MULDIV_OP_MTHI) r_hi <= EX_OperandA;
          if (w_accept && EX_C_Op == MULDIV_OP_MTLO) r_lo <= EX_OperandA;
          if (w_accept && (op_is_mul(EX_C_Op) || op_is_div(EX_C_Op))) begin
            r_sign_a      <= w_neg_a;
            r_sign_b      <= w_neg_b;
            r_is_div      <= op_is_div(EX_C_Op);
            r_div_zero_op <= op_is_div(EX_C_Op) & w_b_zero;
            r_raw_a       <= EX_OperandA;
            r_opb         <= w_abs_b;
            r_cnt         <= CNT_INIT;
            r_acc         <= {{WIDTH{1'b0}}, w_abs_a};
`ifdef MULDIV_FAST_MUL_EN
            if (op_is_mul(EX_C_Op)) r_acc <= w_fast_prod;
`endif
            if (op_is_div(EX_C_Op) && !w_b_zero) r_divzero <= 1'b0;
          end
        end
        ST_MUL: begin
          r_acc <= w_mul_step;
          r_cnt <= r_cnt - CNT_ONE;
        end
        ST_DIV: begin
          r_acc <= w_div_step;
          r_cnt <= r_cnt - CNT_ONE;
        end
        ST_FIX: begin
          r_done <= 1'b1;
          if (r_div_zero_op) begin
            r_hi      <= r_raw_a;
            r_lo      <= '1;
            r_divzero <= 1'b1;
          end else begin
            r_hi <= w_fix_hi;
            r_lo <= w_fix_lo;
          end
        end
        default: ;
      endcase
    end
  end

  assign EX_C_Busy     = (r_state != ST_IDLE);
  assign HZ_C_StallReq = EX_C_Busy & DE_C_ReadHiLo;
  assign EX_C_Done     = r_done;
  assign EX_C_DivZero  = r_divzero;
  assign HI            = r_hi;
  assign LO            = r_lo;

endmodule

`default_nettype wire

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
- Multi-cycle multiply/divide unit for the EX stage. Owns the HI/LO registers.
- Acts as the stall requester toward the pipeline hazard logic: raises a stall request while a HI/LO reader sits in DE and the unit is still computing.
- Its HZ_ outputs OR into the PC/IF-output stall and the DE flush paths.

Parameters:
- WIDTH, 32, operand/HI/LO width.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous reset, active-low
- EX_C_Start  in  1  valid mul/div/mt op in EX this cycle
- EX_C_Op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO
- EX_C_Flush  in  1  EX instruction is squashed; suppresses Start in the same cycle
- EX_OperandA  in  WIDTH  rs value (forwarded)
- EX_OperandB  in  WIDTH  rt value (forwarded)
- DE_C_ReadHiLo  in  1  DE instruction is MFHI/MFLO or a mul/div/mt op
- HZ_C_StallReq  out  1  stall request to hazard logic
- EX_C_Busy  out  1  unit not idle
- EX_C_Done  out  1  one-cycle pulse: HI/LO just updated by mul/div
- EX_C_DivZero  out  1  sticky flag: last divide had divisor 0
- HI  out  WIDTH  HI register
- LO  out  WIDTH  LO register

Behaviour:
- Reset (async, rst_n low): state IDLE, counter 0, HI=0, LO=0, Done=0, DivZero=0. Busy and StallReq are 0.
- States: IDLE, MUL, DIV, FIX.
- Start acceptance: only in IDLE, and only when EX_C_Start=1 and EX_C_Flush=0. Start outside IDLE is ignored; it cannot occur because StallReq holds that instruction in DE.
- MTHI/MTLO: HI or LO takes OperandA at the accepting edge. State stays IDLE; no Busy, no Done.
- MULT/DIV setup at accept:
  - Latch |A|, |B| (for signed ops) or A, B (unsigned). Latch sign bits.
  - Counter = WIDTH.
  - Next state MUL or DIV.
- Divide by zero (B=0): skip DIV and go to FIX directly.
- MUL: radix-2 shift-add, one bit per cycle, 2*WIDTH-bit accumulator, WIDTH cycles.
- DIV: restoring division, one quotient bit per cycle, WIDTH cycles.
- Counter decrements each cycle; at counter==1 go to FIX.
- FIX (one cycle), writes HI/LO at its exit edge, then returns to IDLE; Done=1 the following cycle.
  - MULT: negate the 64-bit product if signA^signB.
  - DIV: negate quotient if signA^signB; remainder takes sign of A.
  - Divide by zero: LO=all ones, HI=OperandA unchanged, DivZero=1.
- DivZero: cleared on any accepted DIV/DIVU with nonzero B.
- Latency: Start at edge 0 → Busy high for WIDTH+1 cycles (33) → Done in cycle 34, with HI/LO valid the same cycle. Divide-by-zero: Busy 1 cycle, Done in cycle 2.
- EX_C_Busy = (state != IDLE). Combinational from the state register.
- HZ_C_StallReq = EX_C_Busy & DE_C_ReadHiLo. Combinational, no registered delay, so the stall is visible the cycle after Start.
- Most-negative signed operand: the absolute value is held as an unsigned WIDTH-bit value, giving correct results. −2^31 / −1 yields LO=0x80000000, HI=0.
- Reset mid-operation aborts immediately; HI/LO return to 0.

Optional Feature:
- MULDIV_FAST_MUL_EN defined:
  - MULT/MULTU use a single-cycle combinational WIDTH×WIDTH multiplier.
  - The accepting edge goes to FIX; Busy 1 cycle, Done in cycle 2.
- Not defined: iterative shift-add multiply as specified above. Divide is iterative in both builds.

Decomposition:
- Shared package:
  - Op encodings (MULDIV_OP_MULT … MULDIV_OP_MTLO).
  - State encodings (ST_IDLE, ST_MUL, ST_DIV, ST_FIX).
  - Default WIDTH.
- One natural sub-module: muldiv_signfix. Purely combinational; takes magnitude results plus signs and returns signed HI/LO.

Test Plan:
- MULT A=0xFFFFFFFD (−3), B=7 → Busy 33 cycles, Done cycle 34: HI=0xFFFFFFFF, LO=0xFFFFFFEB.
- DIVU A=100, B=7 → LO=14, HI=2. Then DIV A=0xFFFFFFF9 (−7), B=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIV B=0, A=0x1234 → Busy 1 cycle, LO=0xFFFFFFFF, HI=0x1234, DivZero=1. Next DIV 9/3 clears DivZero, LO=3.
- MULT started, DE_C_ReadHiLo=1 from cycle 1 → StallReq high cycles 1–33, low in cycle 34 with the correct HI visible. With DE_C_ReadHiLo=0 → StallReq stays 0.
- Start with Flush=1 → no state change; MTLO A=0xA5A5A5A5 → LO updated next cycle, Busy stays 0.
- rst_n low at cycle 10 of a DIV → immediate IDLE, HI=LO=0, Busy=0. Then a fresh MULTU 0xFFFFFFFF×2 → HI=1, LO=0xFFFFFFFE.
